// File: rtl/outlier_fifo_drain.sv
// Drains the outlier-position FIFO into a valid/ready stream, holding one index back so TLAST lands on the true final index.
// Optional build macro DRAIN_RANGE_CHECK_EN discards indices >= point_cloud_size and counts them.
module outlier_fifo_drain #(
    parameter int N           = 16,
    parameter int DONE_SETTLE = 2
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           ctrl_done,
    input  logic           fifo_empty,
    input  logic [N-1:0]   fifo_dout,
    output logic           fifo_rd_en,
    input  logic [2*N-1:0] point_cloud_size,
    output logic [N-1:0]   m_tdata,
    output logic           m_tvalid,
    input  logic           m_tready,
    output logic           m_tlast,
    output logic [N-1:0]   outlier_count,
    output logic [N-1:0]   range_err_count,
    output logic           finished
);

    // state   | meaning
    // IDLE    | one cycle after reset before polling starts
    // FETCH   | pop when FIFO has data, else count done&empty settle cycles
    // CAPTURE | FIFO data arrives; previous lookahead becomes a non-last beat
    // SEND    | non-last beat waiting for m_tready
    // LAST    | lookahead emitted with tlast, waiting for m_tready
    // DONE    | drain complete, sticky until reset
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_SEND,
        S_LAST,
        S_DONE
    } state_t;

    localparam int SW = $clog2(DONE_SETTLE + 2);

    state_t         state_q, state_d;
    logic [N-1:0]   la_q, la_d;
    logic           la_v_q, la_v_d;
    logic [N-1:0]   tdata_q, tdata_d;
    logic           tvalid_q, tvalid_d;
    logic           tlast_q, tlast_d;
    logic [N-1:0]   cnt_q, cnt_d;
    logic [N-1:0]   err_q, err_d;
    logic           finished_q, finished_d;
    logic [SW-1:0]  settle_q, settle_d;
    logic           rd_en_c;
    logic           range_bad;

`ifdef DRAIN_RANGE_CHECK_EN
    assign range_bad = ({{N{1'b0}}, fifo_dout} >= point_cloud_size);
`else
    logic unused_size;
    assign unused_size = ^point_cloud_size;
    assign range_bad   = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            la_q       <= '0;
            la_v_q     <= 1'b0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            cnt_q      <= '0;
            err_q      <= '0;
            finished_q <= 1'b0;
            settle_q   <= '0;
        end else begin
            state_q    <= state_d;
            la_q       <= la_d;
            la_v_q     <= la_v_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            finished_q <= finished_d;
            settle_q   <= settle_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        la_d     = la_q;
        la_v_d   = la_v_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        settle_d = '0;
        rd_en_c  = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (!fifo_empty) begin
                    rd_en_c = 1'b1;
                    state_d = S_CAPTURE;
                end else begin
                    if (ctrl_done)
                        settle_d = (settle_q >= SW'(DONE_SETTLE)) ? settle_q : settle_q + 1'b1;
                    if (settle_q >= SW'(DONE_SETTLE)) begin
                        if (la_v_q) begin
                            tdata_d  = la_q;
                            tvalid_d = 1'b1;
                            tlast_d  = 1'b1;
                            state_d  = S_LAST;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_CAPTURE: begin
                state_d = S_FETCH;
                if (range_bad) begin
                    err_d = (err_q == '1) ? err_q : err_q + 1'b1;
                end else begin
                    la_d   = fifo_dout;
                    la_v_d = 1'b1;
                    if (la_v_q) begin
                        tdata_d  = la_q;
                        tvalid_d = 1'b1;
                        tlast_d  = 1'b0;
                        state_d  = S_SEND;
                    end
                end
            end
            S_SEND: begin
                if (m_tready) begin
                    tvalid_d = 1'b0;
                    cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_LAST: begin
                if (m_tready) begin
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                    la_v_d   = 1'b0;
                    cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE: tvalid_d = 1'b0;
            default: state_d = S_IDLE;
        endcase

        finished_d = finished_q | (state_d == S_DONE);
    end

    // Pop strobe is combinational from state; held off while reset is being applied.
    assign fifo_rd_en      = rd_en_c & ~reset;
    assign m_tdata         = tdata_q;
    assign m_tvalid        = tvalid_q;
    assign m_tlast         = tlast_q;
    assign outlier_count   = cnt_q;
    assign range_err_count = err_q;
    assign finished        = finished_q;

endmodule

// File: tb/tb_outlier_fifo_drain.sv
// Directed bench for outlier_fifo_drain with a standard-FIFO model and a beat logger.
module tb_outlier_fifo_drain;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ctrl_done = 1'b0;
    logic        fifo_empty;
    logic [15:0] fifo_dout = '0;
    logic        fifo_rd_en;
    logic [31:0] point_cloud_size = 32'hFFFF_FFFF;
    logic [15:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic        m_tlast;
    logic [15:0] outlier_count;
    logic [15:0] range_err_count;
    logic        finished;

    int n_vec  = 0;
    int n_miss = 0;

    outlier_fifo_drain #(.N(16), .DONE_SETTLE(2)) dut (
        .clock            (clock),
        .reset            (reset),
        .ctrl_done        (ctrl_done),
        .fifo_empty       (fifo_empty),
        .fifo_dout        (fifo_dout),
        .fifo_rd_en       (fifo_rd_en),
        .point_cloud_size (point_cloud_size),
        .m_tdata          (m_tdata),
        .m_tvalid         (m_tvalid),
        .m_tready         (m_tready),
        .m_tlast          (m_tlast),
        .outlier_count    (outlier_count),
        .range_err_count  (range_err_count),
        .finished         (finished)
    );

    always #5 clock = ~clock;

    // FIFO model: first-word data appears the cycle after the pop strobe
    logic [15:0] mem [64];
    int wp = 0;
    int rp = 0;
    assign fifo_empty = (wp == rp);

    always @(posedge clock) begin
        if (fifo_rd_en && (wp != rp)) begin
            fifo_dout <= mem[rp % 64];
            rp        <= rp + 1;
        end
    end

    // Beat logger and protocol watchers, sampled mid-cycle
    logic [15:0] bd [$];
    logic        bl [$];
    int rd_cnt = 0, rd_viol = 0, stall_viol = 0, tvalid_seen = 0;
    logic        prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0;
    logic [15:0] prev_d = '0;

    always @(negedge clock) begin
        if (!reset) begin
            if (fifo_rd_en) rd_cnt <= rd_cnt + 1;
            if (fifo_rd_en && fifo_empty) rd_viol <= rd_viol + 1;
            if (m_tvalid) tvalid_seen <= tvalid_seen + 1;
            if (prev_v && !prev_r && (!m_tvalid || m_tdata != prev_d || m_tlast != prev_l))
                stall_viol <= stall_viol + 1;
            if (m_tvalid && m_tready) begin
                bd.push_back(m_tdata);
                bl.push_back(m_tlast);
            end
        end
        prev_v <= m_tvalid & ~reset;
        prev_r <= m_tready;
        prev_d <= m_tdata;
        prev_l <= m_tlast;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic push(input logic [15:0] v);
        mem[wp % 64] = v;
        wp = wp + 1;
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        ctrl_done = 1'b0;
        m_tready  = 1'b0;
        step(2);
        chk("rd_en_in_reset", {31'd0, fifo_rd_en}, 32'd0);
        reset = 1'b0;
    endtask

    task automatic wait_finished(input string tag, input int budget);
        for (int i = 0; i < budget && !finished; i++) step(1);
        chk(tag, {31'd0, finished}, 32'd1);
    endtask

    function automatic logic [31:0] beat_d(input int idx);
        return (idx < bd.size()) ? {16'd0, bd[idx]} : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] beat_l(input int idx);
        return (idx < bl.size()) ? {31'd0, bl[idx]} : 32'hFFFF_FFFF;
    endfunction

    initial begin
        int base, tv0, rd0, cyc;

        // Reset values
        step(2);
        chk("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
        chk("rst_tlast", {31'd0, m_tlast}, 32'd0);
        chk("rst_tdata", {16'd0, m_tdata}, 32'd0);
        chk("rst_count", {16'd0, outlier_count}, 32'd0);
        chk("rst_errcnt", {16'd0, range_err_count}, 32'd0);
        chk("rst_finished", {31'd0, finished}, 32'd0);
        chk("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);

        // Three words, then done: 5, 9, 12(last)
        apply_reset();
        base = bd.size();
        m_tready = 1'b1;
        push(16'd5); push(16'd9); push(16'd12);
        step(15);
        chk("t1_beats_pre_done", bd.size() - base, 32'd2);
        ctrl_done = 1'b1;
        wait_finished("t1_finished", 60);
        chk("t1_beats", bd.size() - base, 32'd3);
        chk("t1_d0", beat_d(base), 32'd5);
        chk("t1_l0", beat_l(base), 32'd0);
        chk("t1_d1", beat_d(base + 1), 32'd9);
        chk("t1_l1", beat_l(base + 1), 32'd0);
        chk("t1_d2", beat_d(base + 2), 32'd12);
        chk("t1_l2", beat_l(base + 2), 32'd1);
        chk("t1_count", {16'd0, outlier_count}, 32'd3);
        chk("t1_tvalid_after", {31'd0, m_tvalid}, 32'd0);

        // Zero outliers: done with empty FIFO from the start
        reset = 1'b1; m_tready = 1'b1; ctrl_done = 1'b1;
        step(2);
        tv0 = tvalid_seen;
        reset = 1'b0;
        cyc = 0;
        for (int i = 1; i <= 8 && !finished; i++) begin
            step(1);
            cyc = i;
        end
        chk("t2_finished", {31'd0, finished}, 32'd1);
        chk("t2_within4", {31'd0, (cyc <= 4)}, 32'd1);
        chk("t2_no_tvalid", tvalid_seen - tv0, 32'd0);
        chk("t2_count", {16'd0, outlier_count}, 32'd0);

        // Back-pressure on first beat: 7 held 10 cycles, then 7, 8(last)
        apply_reset();
        base = bd.size();
        rd0 = rd_cnt;
        push(16'd7); push(16'd8);
        for (int i = 0; i < 30 && !m_tvalid; i++) step(1);
        for (int i = 0; i < 10; i++) begin
            chk("t3_stall_valid", {31'd0, m_tvalid}, 32'd1);
            chk("t3_stall_data", {16'd0, m_tdata}, 32'd7);
            step(1);
        end
        chk("t3_rd_during_stall", rd_cnt - rd0, 32'd2);
        m_tready = 1'b1;
        ctrl_done = 1'b1;
        wait_finished("t3_finished", 60);
        chk("t3_beats", bd.size() - base, 32'd2);
        chk("t3_d0", beat_d(base), 32'd7);
        chk("t3_l0", beat_l(base), 32'd0);
        chk("t3_d1", beat_d(base + 1), 32'd8);
        chk("t3_l1", beat_l(base + 1), 32'd1);
        chk("t3_rd_total", rd_cnt - rd0, 32'd2);

        // Empty gap with done low: 3 held in lookahead, never tagged last
        apply_reset();
        base = bd.size();
        tv0 = tvalid_seen;
        m_tready = 1'b1;
        push(16'd3);
        step(25);
        chk("t4_gap_no_beat", bd.size() - base, 32'd0);
        chk("t4_gap_no_tvalid", tvalid_seen - tv0, 32'd0);
        push(16'd4);
        step(10);
        chk("t4_mid_beats", bd.size() - base, 32'd1);
        chk("t4_d0", beat_d(base), 32'd3);
        chk("t4_l0", beat_l(base), 32'd0);
        ctrl_done = 1'b1;
        wait_finished("t4_finished", 60);
        chk("t4_d1", beat_d(base + 1), 32'd4);
        chk("t4_l1", beat_l(base + 1), 32'd1);
        chk("t4_count", {16'd0, outlier_count}, 32'd2);

        // Reset while a beat (6) is pending
        apply_reset();
        push(16'd6); push(16'd7);
        for (int i = 0; i < 30 && !m_tvalid; i++) step(1);
        chk("t5_pending_valid", {31'd0, m_tvalid}, 32'd1);
        chk("t5_pending_data", {16'd0, m_tdata}, 32'd6);
        reset = 1'b1;
        step(1);
        chk("t5_rst_tvalid", {31'd0, m_tvalid}, 32'd0);
        chk("t5_rst_count", {16'd0, outlier_count}, 32'd0);
        chk("t5_rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        reset = 1'b0;
        base = bd.size();
        step(3);
        push(16'd11);
        m_tready = 1'b1;
        ctrl_done = 1'b1;
        wait_finished("t5_finished", 60);
        chk("t5_beats", bd.size() - base, 32'd1);
        chk("t5_d0", beat_d(base), 32'd11);
        chk("t5_l0", beat_l(base), 32'd1);
        chk("t5_count", {16'd0, outlier_count}, 32'd1);

        // Range check: size 100, words 50, 150, 99
        apply_reset();
        base = bd.size();
        point_cloud_size = 32'd100;
        m_tready = 1'b1;
        push(16'd50); push(16'd150); push(16'd99);
        step(15);
        ctrl_done = 1'b1;
        wait_finished("t6_finished", 60);
        chk("t6_d0", beat_d(base), 32'd50);
`ifdef DRAIN_RANGE_CHECK_EN
        chk("t6_beats", bd.size() - base, 32'd2);
        chk("t6_d1", beat_d(base + 1), 32'd99);
        chk("t6_l1", beat_l(base + 1), 32'd1);
        chk("t6_errcnt", {16'd0, range_err_count}, 32'd1);
`else
        chk("t6_beats", bd.size() - base, 32'd3);
        chk("t6_d1", beat_d(base + 1), 32'd150);
        chk("t6_d2", beat_d(base + 2), 32'd99);
        chk("t6_l2", beat_l(base + 2), 32'd1);
        chk("t6_errcnt", {16'd0, range_err_count}, 32'd0);
`endif

        step(2);
        chk("rd_en_while_empty", rd_viol, 32'd0);
        chk("stall_stability", stall_viol, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
